instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. It owns the program counter, drives the word address to the instruction ROM, and captures the combinational read data into an IF/ID pipeline register with a valid flag. It handles stall, flush and branch/jump redirect from downstream stages. It traps misaligned or out-of-window fetches into a sticky fault state.

Parameters:
DATA_WIDTH, 32, instruction and address width
RESET_PC, 32'h0040_0000, text-segment base; first fetch address after reset
MEM_WORDS, 1024, number of 32-bit words in the instruction ROM window starting at RESET_PC

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
imem_address  output  DATA_WIDTH  byte address to instruction ROM; equals pc_reg combinationally
imem_rd  input  DATA_WIDTH  combinational read data from ROM for imem_address
stall  input  1  hold PC and IF/ID register
flush  input  1  invalidate the IF/ID register
redirect_en  input  1  load redirect_pc into PC (taken branch/jump)
redirect_pc  input  DATA_WIDTH  redirect target byte address
instr_out  output  DATA_WIDTH  IF/ID instruction
pc_out  output  DATA_WIDTH  IF/ID PC of instr_out
pc_plus4_out  output  DATA_WIDTH  IF/ID pc_out+4 (for link)
instr_valid  output  1  IF/ID holds a live instruction
fetch_fault  output  1  sticky fault flag

Behaviour:
- Reset (async, rst=1): pc_reg=RESET_PC, state=BOOT, instr_out=0, pc_out=0, pc_plus4_out=0, instr_valid=0, fetch_fault=0. Reset asserted mid-operation discards everything immediately.
- Window check, combinational: in_window = (pc_reg >= RESET_PC) and ((pc_reg-RESET_PC)>>2 < MEM_WORDS). aligned = (pc_reg[1:0]==0). Subtraction is unsigned 32-bit.
- FSM states: BOOT, RUN, FAULT.
- BOOT: one cycle after reset release. No capture; instr_valid=0. Next state is RUN unconditionally.
- RUN: each rising edge evaluates events in priority order:
  1. Fault. If !aligned or !in_window, go to FAULT: fetch_fault<=1, instr_valid<=0, pc_reg holds. This has priority over redirect, stall and flush.
  2. Redirect. If redirect_en=1, pc_reg<=redirect_pc and instr_valid<=0 (the wrong-path word is squashed). This happens even when stall=1. IF/ID data fields hold.
  3. Stall. If stall=1, pc_reg and all IF/ID fields hold. If flush=1 in the same cycle, instr_valid<=0.
  4. Normal. Otherwise instr_out<=imem_rd, pc_out<=pc_reg, pc_plus4_out<=pc_reg+4, pc_reg<=pc_reg+4. instr_valid<=!flush.
- A misaligned or out-of-window redirect_pc is accepted into pc_reg. It faults on the following edge, and that target is never captured.
- Sequential fetch past the last word (RESET_PC+4*MEM_WORDS) faults; the PC does not wrap. The 32-bit pc_reg+4 overflow wraps modulo 2^32, and the wrapped value is caught by the window check.
- FAULT: absorbing state, left only by rst. imem_address=pc_reg (frozen faulting PC), instr_valid=0, fetch_fault=1. stall, flush and redirect are ignored.
- Latency: an instruction at address A appears on instr_out with instr_valid=1 one edge after pc_reg==A in a non-stalled RUN cycle. Throughput is one instruction per cycle.
- instr_valid is not forced low by stall alone. A stalled valid instruction stays valid.

Test Plan:
- Reset then free-run with ROM words W0..W3 at 0x400000..0x40000C -> BOOT cycle has valid=0; then instr_out=W0/pc_out=0x400000/pc_plus4_out=0x400004, then W1, W2, W3 on consecutive cycles, all with valid=1.
- stall=1 for 3 cycles while pc_out=0x400004 -> instr_out, pc_out and pc_reg unchanged, valid stays 1. On release, the next capture is pc_out=0x400008.
- redirect_en=1, redirect_pc=0x400020, with stall=1 in the same cycle -> next edge valid=0 and imem_address=0x400020. The following edge gives pc_out=0x400020 with valid=1.
- flush=1 alone at pc_reg=0x400008 -> valid=0 that cycle while pc_reg advances to 0x40000C. The next capture is pc_out=0x40000C.
- redirect_pc=0x400002 -> one edge later fetch_fault=1 and valid=0. It stays that way through further stall/redirect until rst, after which pc=0x400000 and fault=0.
- Sequential run to 0x400FFC (MEM_WORDS=1024) -> that word is captured valid. The next edge faults with imem_address=0x401000 frozen.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM address and
// captures the returned word into the IF/ID register, trapping bad fetches.
module instr_fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
   parameter int                    MEM_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [DATA_WIDTH-1:0] imem_address,
   input  logic [DATA_WIDTH-1:0] imem_rd,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  redirect_en,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic [DATA_WIDTH-1:0] instr_out,
   output logic [DATA_WIDTH-1:0] pc_out,
   output logic [DATA_WIDTH-1:0] pc_plus4_out,
   output logic                  instr_valid,
   output logic                  fetch_fault
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [DATA_WIDTH-1:0] MEM_WORDS_W = DATA_WIDTH'(MEM_WORDS);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [DATA_WIDTH-1:0] pc_id_q, pc_id_d;
   logic [DATA_WIDTH-1:0] pc4_id_q, pc4_id_d;
   logic                  valid_q, valid_d;
   logic                  fault_q, fault_d;

   logic [DATA_WIDTH-1:0] pc_plus4;
   logic [DATA_WIDTH-1:0] pc_offset;
   logic                  in_window;
   logic                  aligned;

   // Unsigned offset: any PC below the base wraps to a huge value, but the
   // explicit lower-bound compare keeps the intent obvious.
   assign pc_plus4  = pc_q + DATA_WIDTH'(4);
   assign pc_offset = pc_q - RESET_PC;
   assign in_window = (pc_q >= RESET_PC) && ((pc_offset >> 2) < MEM_WORDS_W);
   assign aligned   = (pc_q[1:0] == 2'b00);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc_id_d  = pc_id_q;
      pc4_id_d = pc4_id_q;
      valid_d  = valid_q;
      fault_d  = fault_q;

      unique case (state_q)
         BOOT: begin
            state_d = RUN;
            valid_d = 1'b0;
         end
         RUN: begin
            if (!aligned || !in_window) begin
               state_d = FAULT;
               fault_d = 1'b1;
               valid_d = 1'b0;
            end else if (redirect_en) begin
               pc_d    = redirect_pc;
               valid_d = 1'b0;
            end else if (stall) begin
               if (flush) valid_d = 1'b0;
            end else begin
               instr_d  = imem_rd;
               pc_id_d  = pc_q;
               pc4_id_d = pc_plus4;
               pc_d     = pc_plus4;
               valid_d  = !flush;
            end
         end
         FAULT: begin
            valid_d = 1'b0;
            fault_d = 1'b1;
         end
         default: begin
            state_d = FAULT;
            valid_d = 1'b0;
            fault_d = 1'b1;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         pc_id_q  <= '0;
         pc4_id_q <= '0;
         valid_q  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc_id_q  <= pc_id_d;
         pc4_id_q <= pc4_id_d;
         valid_q  <= valid_d;
         fault_q  <= fault_d;
      end
   end

   assign imem_address = pc_q;
   assign instr_out    = instr_q;
   assign pc_out       = pc_id_q;
   assign pc_plus4_out = pc4_id_q;
   assign instr_valid  = valid_q;
   assign fetch_fault  = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: each step queues the expected IF/ID
// snapshot, advances one edge and checks the DUT against the popped entry.
module tb_instr_fetch_unit;

   typedef struct {
      logic        valid;
      logic [31:0] pc_id;
      logic [31:0] addr;
      logic        fault;
      string       tag;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] imem_address;
   logic [31:0] imem_rd;
   logic        stall;
   logic        flush;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4_out;
   logic        instr_valid;
   logic        fetch_fault;

   int   tests_run = 0;
   int   tests_failed = 0;
   exp_t sb_q[$];

   instr_fetch_unit #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0040_0000),
      .MEM_WORDS  (1024)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_address (imem_address),
      .imem_rd      (imem_rd),
      .stall        (stall),
      .flush        (flush),
      .redirect_en  (redirect_en),
      .redirect_pc  (redirect_pc),
      .instr_out    (instr_out),
      .pc_out       (pc_out),
      .pc_plus4_out (pc_plus4_out),
      .instr_valid  (instr_valid),
      .fetch_fault  (fetch_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Address-dependent ROM contents, so a wrong capture address shows up in the data.
   function automatic logic [31:0] rom(input logic [31:0] a);
      return {~a[15:0], a[15:0] ^ 16'h5A5A};
   endfunction

   assign imem_rd = rom(imem_address);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic s, input logic f, input logic re,
                       input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                       input logic [31:0] eaddr, input logic efault);
      exp_t e, got;
      stall       = s;
      flush       = f;
      redirect_en = re;
      redirect_pc = rpc;
      e.valid = ev;
      e.pc_id = epc;
      e.addr  = eaddr;
      e.fault = efault;
      e.tag   = tag;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check({got.tag, ".valid"}, 32'(instr_valid), 32'(got.valid));
      check({got.tag, ".pc_out"}, pc_out, got.pc_id);
      check({got.tag, ".pc4"}, pc_plus4_out, (got.pc_id == 32'h0) ? 32'h0 : got.pc_id + 32'd4);
      check({got.tag, ".instr"}, instr_out, (got.pc_id == 32'h0) ? 32'h0 : rom(got.pc_id));
      check({got.tag, ".addr"}, imem_address, got.addr);
      check({got.tag, ".fault"}, 32'(fetch_fault), 32'(got.fault));
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      check({tag, ".addr"}, imem_address, 32'h0040_0000);
      check({tag, ".valid"}, 32'(instr_valid), 32'h0);
      check({tag, ".fault"}, 32'(fetch_fault), 32'h0);
      check({tag, ".pc_out"}, pc_out, 32'h0);
      check({tag, ".instr"}, instr_out, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      stall       = 1'b0;
      flush       = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 32'h0;
      #2;
      do_reset("rst0");

      // Free run: BOOT bubble then W0..W3
      step("boot",  0, 0, 0, 0, 0, 32'h0,        32'h0040_0000, 0);
      step("w0",    0, 0, 0, 0, 1, 32'h0040_0000, 32'h0040_0004, 0);
      step("w1",    0, 0, 0, 0, 1, 32'h0040_0004, 32'h0040_0008, 0);
      step("w2",    0, 0, 0, 0, 1, 32'h0040_0008, 32'h0040_000C, 0);
      step("w3",    0, 0, 0, 0, 1, 32'h0040_000C, 32'h0040_0010, 0);

      // Stall for three cycles while pc_out=0x400004
      step("rd0",   0, 0, 1, 32'h0040_0000, 0, 32'h0040_000C, 32'h0040_0000, 0);
      step("r0",    0, 0, 0, 0, 1, 32'h0040_0000, 32'h0040_0004, 0);
      step("r1",    0, 0, 0, 0, 1, 32'h0040_0004, 32'h0040_0008, 0);
      for (int i = 0; i < 3; i++)
         step("stall", 1, 0, 0, 0, 1, 32'h0040_0004, 32'h0040_0008, 0);
      step("unstl", 0, 0, 0, 0, 1, 32'h0040_0008, 32'h0040_000C, 0);

      // Flush alone at pc_reg=0x400008
      step("rd8",   0, 0, 1, 32'h0040_0008, 0, 32'h0040_0008, 32'h0040_0008, 0);
      step("flush", 0, 1, 0, 0, 0, 32'h0040_0008, 32'h0040_000C, 0);
      step("aftfl", 0, 0, 0, 0, 1, 32'h0040_000C, 32'h0040_0010, 0);

      // Redirect wins over a simultaneous stall
      step("rdstl", 1, 0, 1, 32'h0040_0020, 0, 32'h0040_000C, 32'h0040_0020, 0);
      step("tgt",   0, 0, 0, 0, 1, 32'h0040_0020, 32'h0040_0024, 0);

      // Stall plus flush drops valid, holds everything else
      step("stfl",  1, 1, 0, 0, 0, 32'h0040_0020, 32'h0040_0024, 0);
      step("t24",   0, 0, 0, 0, 1, 32'h0040_0024, 32'h0040_0028, 0);

      // Misaligned redirect target: accepted, then faults and sticks
      step("rdmis", 0, 0, 1, 32'h0040_0002, 0, 32'h0040_0024, 32'h0040_0002, 0);
      step("flt",   0, 0, 0, 0, 0, 32'h0040_0024, 32'h0040_0002, 1);
      step("fltst", 1, 1, 1, 32'h0040_0040, 0, 32'h0040_0024, 32'h0040_0002, 1);
      step("fltrd", 0, 0, 1, 32'h0040_0000, 0, 32'h0040_0024, 32'h0040_0002, 1);

      // Mid-operation reset clears the fault
      @(negedge clk);
      do_reset("rst1");

      // Sequential run off the end of the window
      step("boot2", 0, 0, 0, 0, 0, 32'h0,         32'h0040_0000, 0);
      step("rdend", 0, 0, 1, 32'h0040_0FF0, 0, 32'h0,         32'h0040_0FF0, 0);
      step("e0",    0, 0, 0, 0, 1, 32'h0040_0FF0, 32'h0040_0FF4, 0);
      step("e1",    0, 0, 0, 0, 1, 32'h0040_0FF4, 32'h0040_0FF8, 0);
      step("e2",    0, 0, 0, 0, 1, 32'h0040_0FF8, 32'h0040_0FFC, 0);
      step("last",  0, 0, 0, 0, 1, 32'h0040_0FFC, 32'h0040_1000, 0);
      step("eflt",  0, 0, 0, 0, 0, 32'h0040_0FFC, 32'h0040_1000, 1);
      step("ehold", 0, 0, 0, 0, 0, 32'h0040_0FFC, 32'h0040_1000, 1);

      // Below-base target faults even with a redirect on the faulting edge
      do_reset("rst2");
      step("boot3", 0, 0, 0, 0, 0, 32'h0,         32'h0040_0000, 0);
      step("rdlow", 0, 0, 1, 32'h003F_FFFC, 0, 32'h0,         32'h003F_FFFC, 0);
      step("lflt",  0, 0, 1, 32'h0040_0000, 0, 32'h0,         32'h003F_FFFC, 1);

      // Top of the address space is outside the window
      do_reset("rst3");
      step("boot4", 0, 0, 0, 0, 0, 32'h0,         32'h0040_0000, 0);
      step("rdtop", 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'hFFFF_FFFC, 0);
      step("tflt",  0, 0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 1);

      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #20000;
      tests_failed++;
      $display("FAIL timeout: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "timeout");
   end

endmodule
